// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hazard_ctrl_pkg
// Description : Shared definitions for the pipeline hazard/flush controller.
//               It holds the MDU timer state encoding, the PcSel codes, the
//               exception vector and the default MDU latencies.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // MDU busy-timer states
  typedef enum logic [0:0] {
    HC_IDLE = 1'b0,
    HC_BUSY = 1'b1
  } hc_state_e;

  // Next-PC source select
  localparam logic [1:0] PC_SEQ = 2'b00;  // sequential or branch target
  localparam logic [1:0] PC_EXC = 2'b01;  // exception vector
  localparam logic [1:0] PC_EPC = 2'b10;  // return through EPC

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  // Default MDU latencies; both must fit the 4-bit busy counter
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int MDU_CNT_W       = 4;

  // Exception entry has priority over eret when both reach M together.
  function automatic logic [1:0] pc_sel_f(input logic exc, input logic eret);
    if (exc)       return PC_EXC;
    else if (eret) return PC_EPC;
    else           return PC_SEQ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_mdu_busy_timer.sv
`default_nettype none
// ============================================================================
// Module      : mdu_busy_timer
// Description : Tracks how long the multiply/divide unit is still working.
//               A start loads the counter with the op latency; Busy stays
//               high for exactly that many cycles afterwards.
// Ports       : Clk, Rst    - clock, synchronous active-high reset
//               StartOk     - qualified (non-squashed) MDU start in E
//               IsDiv       - 1 = div/divu latency, 0 = mult/multu latency
//               Busy        - MDU result not yet available
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_busy_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic Clk,
  input  logic Rst,
  input  logic StartOk,
  input  logic IsDiv,
  output logic Busy
);

  localparam logic [MDU_CNT_W-1:0] c_mult_load = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] c_div_load  = MDU_CNT_W'(DIV_CYCLES);

  hc_state_e              r_state;
  hc_state_e              w_next_state;
  logic [MDU_CNT_W-1:0]   r_cnt;
  logic [MDU_CNT_W-1:0]   w_next_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= HC_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (StartOk) begin
      // A start while already busy simply restarts the timer.
      w_next_state = HC_BUSY;
      w_next_cnt   = IsDiv ? c_div_load : c_mult_load;
    end else if (r_state == HC_BUSY) begin
      w_next_cnt = r_cnt - 1'b1;
      if (r_cnt == MDU_CNT_W'(1)) begin
        w_next_state = HC_IDLE;
      end
    end
  end

  assign Busy = (r_state == HC_BUSY);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard and flush controller for the five-stage MIPS
//               core. Generates PC/IF-ID stalls, the ID/EX bubble, the global
//               CP0 flush and next-PC select, tracks the MDU busy window and
//               counts stall cycles.
// Ports       : Clk, Rst            - clock, synchronous active-high reset
//               LoadUseD            - load-use hazard on the instruction in D
//               MduOpD              - MDU-dependent instruction in D
//               MduStartE/MduIsDivE - MDU operation start in E and its kind
//               ExcReqM, EretM      - exception accepted / eret in M
//               StallF/StallD/FlushE- stall PC, stall IF/ID, bubble ID/EX
//               FlushAll, PcSel     - global flush and next-PC source
//               MduBusy             - MDU result pending
//               StallCnt            - count of cycles with StallD high
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        LoadUseD,
  input  logic        MduOpD,
  input  logic        MduStartE,
  input  logic        MduIsDivE,
  input  logic        ExcReqM,
  input  logic        EretM,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        FlushAll,
  output logic [1:0]  PcSel,
  output logic        MduBusy,
  output logic [31:0] StallCnt
);

  logic        w_flush_all;
  logic        w_start_ok;
  logic        w_mdu_busy;
  logic        w_mdu_stall;
  logic        w_stall;
  logic [31:0] r_stall_cnt;

  assign w_flush_all = ExcReqM | EretM;

  // A start seen during a flush belongs to a squashed instruction.
  assign w_start_ok = MduStartE & ~w_flush_all;

  mdu_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_busy_timer (
    .Clk     (Clk),
    .Rst     (Rst),
    .StartOk (w_start_ok),
    .IsDiv   (MduIsDivE),
    .Busy    (w_mdu_busy)
  );

  // Including MduStartE covers the start cycle itself, before Busy rises.
  assign w_mdu_stall = MduOpD & (w_mdu_busy | MduStartE);

  // The flush must win so the redirected PC is actually loaded.
  assign w_stall = (LoadUseD | w_mdu_stall) & ~w_flush_all;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign StallF   = w_stall;
  assign StallD   = w_stall;
  assign FlushE   = w_stall;
  assign FlushAll = w_flush_all;
  assign PcSel    = pc_sel_f(ExcReqM, EretM);
  assign MduBusy  = w_mdu_busy;
  assign StallCnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. A cycle-level model
//               (remaining-busy-cycles count plus stall total) is compared
//               with every output on each falling edge; directed scenarios
//               add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        LoadUseD, MduOpD, MduStartE, MduIsDivE, ExcReqM, EretM;
  logic        StallF, StallD, FlushE, FlushAll, MduBusy;
  logic [1:0]  PcSel;
  logic [31:0] StallCnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .LoadUseD  (LoadUseD),
    .MduOpD    (MduOpD),
    .MduStartE (MduStartE),
    .MduIsDivE (MduIsDivE),
    .ExcReqM   (ExcReqM),
    .EretM     (EretM),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushE    (FlushE),
    .FlushAll  (FlushAll),
    .PcSel     (PcSel),
    .MduBusy   (MduBusy),
    .StallCnt  (StallCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_rem: cycles of MDU latency still outstanding (busy while > 0)
  int          m_rem   = 0;
  logic [31:0] m_cnt   = '0;
  bit          m_valid = 1'b0;

  function automatic bit mdl_flush();
    return ExcReqM | EretM;
  endfunction

  function automatic bit mdl_stall();
    bit hazard;
    hazard = LoadUseD | (MduOpD & ((m_rem > 0) | MduStartE));
    return hazard & ~mdl_flush();
  endfunction

  function automatic logic [1:0] mdl_pcsel();
    if (ExcReqM)    return 2'd1;
    else if (EretM) return 2'd2;
    else            return 2'd0;
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      m_rem   = 0;
      m_cnt   = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (mdl_stall()) m_cnt = m_cnt + 32'd1;
      if (MduStartE && !mdl_flush()) m_rem = MduIsDivE ? 10 : 5;
      else if (m_rem > 0)            m_rem = m_rem - 1;
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      chk("m_flushall", {31'd0, FlushAll}, {31'd0, mdl_flush()});
      chk("m_pcsel",    {30'd0, PcSel},    {30'd0, mdl_pcsel()});
      chk("m_stallf",   {31'd0, StallF},   {31'd0, mdl_stall()});
      chk("m_stalld",   {31'd0, StallD},   {31'd0, mdl_stall()});
      chk("m_flushe",   {31'd0, FlushE},   {31'd0, mdl_stall()});
      chk("m_mdubusy",  {31'd0, MduBusy},  {31'd0, m_rem > 0});
      chk("m_stallcnt", StallCnt, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    LoadUseD = 0; MduOpD = 0; MduStartE = 0; MduIsDivE = 0; ExcReqM = 0; EretM = 0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
  endtask

  // Start already applied for this cycle with MduOpD held; run until the
  // MDU-dependent instruction leaves D, counting stall and busy cycles.
  task automatic measure(output int ns, output int nb);
    bit done;
    ns = 0; nb = 0; done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (StallD)  ns++;
      if (MduBusy) nb++;
      done = !StallD;
      cyc();
      MduStartE = 1'b0;
      if (done) break;
    end
    MduOpD = 1'b0;
    chk("measure_bound", {31'd0, done}, 32'd1);
  endtask

  typedef struct packed {
    logic lu, op, st, dv, exc, eret;
  } vec_t;

  vec_t vecs [0:11];

  initial begin
    int ns, nb;
    idle_inputs();
    Rst = 1'b1;
    cyc();
    cyc();
    Rst = 1'b0;

    // reset state
    @(negedge Clk);
    chk("reset_busy", {31'd0, MduBusy}, 32'd0);
    chk("reset_cnt",  StallCnt, 32'd0);

    // mult with mflo waiting in D
    cyc();
    MduStartE = 1; MduIsDivE = 0; MduOpD = 1;
    measure(ns, nb);
    chk("mult_stall_cycles", ns, 6);
    chk("mult_busy_cycles",  nb, 5);
    @(negedge Clk);
    chk("mult_stallcnt", StallCnt, 32'd6);

    // div with MDU op held in D
    cyc();
    do_reset();
    MduStartE = 1; MduIsDivE = 1; MduOpD = 1;
    measure(ns, nb);
    chk("div_stall_cycles", ns, 11);
    chk("div_busy_cycles",  nb, 10);
    @(negedge Clk);
    chk("div_stallcnt", StallCnt, 32'd11);

    // single load-use hazard
    cyc();
    do_reset();
    LoadUseD = 1;
    @(negedge Clk);
    chk("lu_stallf", {31'd0, StallF}, 32'd1);
    chk("lu_flushe", {31'd0, FlushE}, 32'd1);
    cyc();
    LoadUseD = 0;
    @(negedge Clk);
    chk("lu_stalld_after", {31'd0, StallD}, 32'd0);
    chk("lu_stallcnt", StallCnt, 32'd1);

    // exception together with an MDU start and a load-use hazard
    cyc();
    ExcReqM = 1; MduStartE = 1; LoadUseD = 1; MduOpD = 1;
    @(negedge Clk);
    chk("exc_flushall", {31'd0, FlushAll}, 32'd1);
    chk("exc_pcsel",    {30'd0, PcSel},    32'd1);
    chk("exc_stalld",   {31'd0, StallD},   32'd0);
    cyc();
    idle_inputs();
    @(negedge Clk);
    chk("exc_no_busy",  {31'd0, MduBusy}, 32'd0);
    chk("exc_stallcnt", StallCnt, 32'd1);

    // eret while the MDU counter holds 4
    cyc();
    MduStartE = 1; MduIsDivE = 0;
    cyc();
    MduStartE = 0;
    cyc();
    EretM = 1;
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (k == 0) begin
        chk("eret_flushall", {31'd0, FlushAll}, 32'd1);
        chk("eret_pcsel",    {30'd0, PcSel},    32'd2);
      end
      if (!MduBusy) break;
      nb++;
      cyc();
      EretM = 0;
    end
    chk("eret_busy_tail", nb, 4);
    cyc();
    ExcReqM = 1; EretM = 1;
    @(negedge Clk);
    chk("exc_eret_pcsel", {30'd0, PcSel}, 32'd1);
    cyc();
    idle_inputs();

    // reset in the middle of a div
    do_reset();
    MduStartE = 1; MduIsDivE = 1; MduOpD = 1;
    cyc();
    MduStartE = 0;
    cyc();
    cyc();
    Rst = 1;
    cyc();
    Rst = 0; MduOpD = 0;
    @(negedge Clk);
    chk("rst_mid_busy", {31'd0, MduBusy}, 32'd0);
    chk("rst_mid_cnt",  StallCnt, 32'd0);

    // counter wrap
    cyc();
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    @(negedge Clk);
    chk("wrap_preload", StallCnt, 32'hFFFF_FFFF);
    cyc();
    LoadUseD = 1;
    cyc();
    LoadUseD = 0;
    @(negedge Clk);
    chk("wrap_zero", StallCnt, 32'h0000_0000);
    LoadUseD = 1;
    cyc();
    LoadUseD = 0;
    @(negedge Clk);
    chk("wrap_one", StallCnt, 32'h0000_0001);

    // mixed vectors checked by the model only
    vecs[0]  = '{lu:0, op:0, st:1, dv:0, exc:0, eret:0};
    vecs[1]  = '{lu:1, op:1, st:0, dv:0, exc:0, eret:0};
    vecs[2]  = '{lu:0, op:1, st:0, dv:0, exc:0, eret:1};
    vecs[3]  = '{lu:0, op:1, st:0, dv:0, exc:0, eret:0};
    vecs[4]  = '{lu:1, op:0, st:0, dv:0, exc:1, eret:0};
    vecs[5]  = '{lu:0, op:0, st:0, dv:0, exc:0, eret:0};
    vecs[6]  = '{lu:0, op:0, st:0, dv:0, exc:0, eret:0};
    vecs[7]  = '{lu:0, op:1, st:1, dv:1, exc:0, eret:0};
    vecs[8]  = '{lu:0, op:0, st:1, dv:0, exc:0, eret:0};
    vecs[9]  = '{lu:1, op:1, st:0, dv:0, exc:0, eret:0};
    vecs[10] = '{lu:0, op:1, st:0, dv:0, exc:1, eret:1};
    vecs[11] = '{lu:0, op:1, st:0, dv:0, exc:0, eret:0};
    for (int i = 0; i < 12; i++) begin
      cyc();
      LoadUseD  = vecs[i].lu;
      MduOpD    = vecs[i].op;
      MduStartE = vecs[i].st;
      MduIsDivE = vecs[i].dv;
      ExcReqM   = vecs[i].exc;
      EretM     = vecs[i].eret;
    end
    cyc();
    idle_inputs();
    for (int i = 0; i < 12; i++) cyc();
    @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the five-stage MIPS core. It drives the stall enables of the PC and the IF/ID register, the bubble input of the ID/EX register, and the flush input that every pipeline register (EX/MEM included) uses as its CP0 flush. It owns the multiply/divide unit's busy counter, so it can hold MDU-dependent instructions in D until the result exists. It also keeps a free-running stall-cycle performance counter.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start
- Clk  in  1  clock; all state updates on posedge
- Rst  in  1  synchronous, active-high reset
- LoadUseD  in  1  instruction in D reads a GPR that a load in E will write
- MduOpD  in  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- MduStartE  in  1  mult/multu/div/divu is in E this cycle
- MduIsDivE  in  1  qualifies MduStartE: 1 = div/divu, 0 = mult/multu
- ExcReqM  in  1  CP0 accepts an exception or interrupt on the instruction in M
- EretM  in  1  eret is in M
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- FlushE  out  1  load a bubble (all zeros) into ID/EX
- FlushAll  out  1  clear IF/ID, ID/EX, EX/MEM and MEM/WB at the next edge
- PcSel  out  2  00 sequential/branch, 01 exception vector 0x0000_4180, 10 EPC
- MduBusy  out  1  MDU result not yet available
- StallCnt  out  32  number of cycles in which StallD was 1

## Operation
- FlushAll = ExcReqM | EretM. This is combinational, the same cycle as the request.
- PcSel = 01 if ExcReqM; else 10 if EretM; else 00. ExcReqM wins over EretM.
- MDU FSM has two states, IDLE and BUSY, plus a counter Cnt[3:0].
  - Cnt is loaded with DIV_CYCLES if MduIsDivE, else MULT_CYCLES.
- StartOk = MduStartE & ~FlushAll. A start in E during a flush belongs to a squashed instruction and is ignored.
- Transitions:
  - IDLE -> BUSY on StartOk; Cnt is loaded.
  - BUSY: Cnt decrements each cycle. BUSY -> IDLE when Cnt = 1.
  - StartOk while in BUSY reloads Cnt and stays in BUSY. Design intent is that this never happens; the reload is defined defensively.
- An MDU operation already running when FlushAll arrives continues to completion; the counter is not cleared.
- MduBusy = (state == BUSY).
- MduStall = MduOpD & (MduBusy | MduStartE).
- Stall = (LoadUseD | MduStall) & ~FlushAll.
- StallF = StallD = FlushE = Stall. FlushAll overrides all stalls so the redirected PC loads.
- StallCnt increments by 1 on each edge where StallD = 1 and wraps from 0xFFFF_FFFF to 0.
- Reset values:
  - state IDLE, Cnt 0, StallCnt 0.
  - MduBusy 0 from the cycle after the Rst edge.
  - The combinational outputs follow their inputs during Rst.
- Rst in the middle of an MDU operation aborts it: MduBusy is 0 in the next cycle.

## Timing
- All control outputs except MduBusy and StallCnt are combinational from the inputs, with zero latency.
- A start in cycle t makes MduBusy high for cycles t+1 through t+N (N = MULT_CYCLES or DIV_CYCLES) and low in t+N+1.
- An MDU op in D behind a start in cycle t is stalled in cycles t through t+N and enters E in cycle t+N+1.
- Load-use hazard: exactly one stall cycle per occurrence, because the load moves on to M.
- LoadUseD and MduStall together produce a single stall per cycle; StallCnt increments once.
- ExcReqM together with MduStartE: the flush happens, no MDU start, no stall.

## Structure
- Shared package or header MACRO.v holds:
  - state encodings HC_IDLE and HC_BUSY
  - PcSel codes PC_SEQ, PC_EXC, PC_EPC
  - the exception vector 32'h0000_4180
  - default cycle counts
- One sub-module, mdu_busy_timer: the FSM and Cnt, with inputs StartOk and IsDiv and output Busy.
- The stall/flush logic and StallCnt live in the top module.

## Test plan
- Reset, then mult in E at cycle 2 (MduStartE = 1, MduIsDivE = 0) with mflo in D -> StallD high in cycles 2–7, mflo enters E in cycle 8, MduBusy high in cycles 3–7, StallCnt = 6.
- div start, then MduOpD held high -> StallD high for 11 cycles, MduBusy for 10, StallCnt = 11.
- LoadUseD pulse for one cycle with no MDU activity -> StallF = StallD = FlushE = 1 for exactly one cycle, StallCnt = 1.
- ExcReqM and MduStartE together, with LoadUseD = 1 -> FlushAll = 1, PcSel = 01, Stall = 0, MduBusy stays 0 the next cycle.
- EretM during MduBusy with Cnt = 4 -> FlushAll = 1, PcSel = 10, MduBusy still falls after 4 more cycles; ExcReqM and EretM together -> PcSel = 01.
- Rst asserted mid-div -> MduBusy 0 and StallCnt 0 the next cycle; preload StallCnt near 0xFFFF_FFFF by forcing, then stall twice -> wraps to 0x0000_0000, then 0x0000_0001.
